// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter with an input FIFO.
//
// Words enter through a valid/ready handshake into a small FIFO. The frame
// engine pops a word, sends start, DATA_W data bits (LSB first), an optional
// parity bit and one or two stop bits. Each bit lasts OVERSAMPLE baud ticks.
// Queued words go out back-to-back. A line break holds the line low between
// frames.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   baud_tick_i   one-cycle pulse at OVERSAMPLE x baud rate
//   parity_en_i   append parity bit (sampled at frame start)
//   parity_odd_i  1 = odd parity, 0 = even (sampled at frame start)
//   stop2_i       two stop bits when 1 (sampled at frame start)
//   break_i       request line break; honoured only between frames
//   s_valid_i     write strobe
//   s_data_i      write data
//   s_ready_o     FIFO can accept a word
//   tx_o          serial line, idle high
//   busy_o        frame in progress or FIFO non-empty
//   fifo_level_o  number of queued words
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          baud_tick_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          stop2_i,
  input  logic                          break_i,
  input  logic                          s_valid_i,
  input  logic [DATA_W-1:0]             s_data_i,
  output logic                          s_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  // FIFO storage and pointers
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [DATA_W-1:0] head;
  logic              push;
  logic              pop;
  logic              fifo_empty;

  // Frame engine state
  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              par_bit;
  logic              par_en_lat;
  logic              stop2_lat;
  logic              bit_done;
  logic              stop_done;

  assign fifo_empty   = (level == '0);
  assign s_ready_o    = (level != LVL_W'(FIFO_DEPTH));
  // s_ready_o depends only on the registered level, so a full FIFO refuses a
  // push even when the engine pops in the same cycle.
  assign push         = s_valid_i && s_ready_o;
  assign head         = mem[rd_ptr];
  assign fifo_level_o = level;
  assign busy_o       = (state != IDLE) || !fifo_empty;

  assign bit_done  = baud_tick_i && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign stop_done = bit_done && (state == STOP) && (bit_cnt == BIT_W'(stop2_lat));
  // Pop from IDLE, or at the end of the last stop bit for gapless framing.
  // A pending break takes priority over queued data.
  assign pop = !fifo_empty && !break_i && ((state == IDLE) || stop_done);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= s_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      tx_o       <= 1'b1;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      par_en_lat <= 1'b0;
      stop2_lat  <= 1'b0;
    end else begin
      // Ticks only count inside a frame; every bit starts from zero.
      if (state == IDLE || state == BREAK) begin
        tick_cnt <= '0;
      end else if (baud_tick_i) begin
        tick_cnt <= bit_done ? '0 : tick_cnt + TICK_W'(1);
      end

      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (break_i) begin
            state <= BREAK;
            tx_o  <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            state   <= DATA;
            tx_o    <= shift[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              bit_cnt <= '0;
              if (par_en_lat) begin
                state <= PARITY;
                tx_o  <= par_bit;
              end else begin
                state <= STOP;
                tx_o  <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              shift   <= shift >> 1;
              tx_o    <= shift[1];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state   <= STOP;
            tx_o    <= 1'b1;
            bit_cnt <= '0;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (!stop_done) begin
              bit_cnt <= bit_cnt + BIT_W'(1);   // first of two stop bits
            end else if (break_i) begin
              state <= BREAK;
              tx_o  <= 1'b0;
            end else begin
              state <= IDLE;
              tx_o  <= 1'b1;
            end
          end
        end
        BREAK: begin
          if (!break_i) begin
            state <= IDLE;
            tx_o  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx_o  <= 1'b1;
        end
      endcase

      // Loading a new frame overrides whatever the case above chose.
      // Configuration is captured here so mid-frame changes wait a frame.
      if (pop) begin
        state      <= START;
        tx_o       <= 1'b0;
        bit_cnt    <= '0;
        shift      <= head;
        par_bit    <= (^head) ^ parity_odd_i;
        par_en_lat <= parity_en_i;
        stop2_lat  <= stop2_i;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo (DATA_W=8, OVERSAMPLE=16, FIFO_DEPTH=4).
module tb_uart_tx_fifo;

  localparam int DW = 8;
  localparam int OS = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          baud_tick_i = 1'b1;
  logic          parity_en_i = 1'b0;
  logic          parity_odd_i = 1'b0;
  logic          stop2_i = 1'b0;
  logic          break_i = 1'b0;
  logic          s_valid_i = 1'b0;
  logic [DW-1:0] s_data_i = '0;
  logic          s_ready_o;
  logic          tx_o;
  logic          busy_o;
  logic [2:0]    fifo_level_o;

  int checks = 0;
  int passed = 0;
  logic hist [700];

  always #5 clk_i = ~clk_i;

  uart_tx_fifo #(.DATA_W(DW), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .baud_tick_i  (baud_tick_i),
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
    .stop2_i      (stop2_i),
    .break_i      (break_i),
    .s_valid_i    (s_valid_i),
    .s_data_i     (s_data_i),
    .s_ready_o    (s_ready_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .fifo_level_o (fifo_level_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  // Push one word: valid for a single cycle.
  task automatic push1(input logic [DW-1:0] d);
    @(negedge clk_i);
    s_valid_i = 1'b1;
    s_data_i  = d;
    @(negedge clk_i);
    s_valid_i = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk_i);
    check({tag, " busy"}, 32'(busy_o), 32'd0);
    check({tag, " tx"}, 32'(tx_o), 32'd1);
  endtask

  // Check one frame cycle by cycle, one comparison per bit (mismatching cycles
  // must be 0). skip==0: wait up to max_wait cycles for the start bit.
  // skip>0: the start bit is already skip samples old. At the first cycle of
  // bit act_bit, parity_en_i and break_i are driven to act_pen / act_brk.
  task automatic frame(input string tag, input logic [DW-1:0] data,
                       input logic pen, input logic podd, input logic s2,
                       input int max_wait, input int skip,
                       input int act_bit, input logic act_pen, input logic act_brk);
    logic exp_bits[$];
    int w;
    int errs;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_bits.push_back(data[i]);
    if (pen) exp_bits.push_back((^data) ^ podd);
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);
    @(negedge clk_i);
    if (skip == 0) begin
      w = 0;
      while (tx_o !== 1'b0 && w < max_wait) begin
        @(negedge clk_i);
        w++;
      end
    end
    errs = 0;
    for (int s = skip; s < exp_bits.size() * OS; s++) begin
      if (s != skip) @(negedge clk_i);
      if (s == act_bit * OS) begin
        parity_en_i = act_pen;
        break_i     = act_brk;
      end
      if (tx_o !== exp_bits[s / OS]) errs++;
      if (s % OS == OS - 1) begin
        check($sformatf("%s bit%0d", tag, s / OS), 32'(errs), 32'd0);
        errs = 0;
      end
    end
  endtask

  initial begin
    int lows;
    int busyc;
    int run;
    int nruns;
    int second;
    int exp_lvl [6];
    logic exp_rdy [6];
    exp_lvl = '{0, 1, 1, 2, 3, 4};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // 1: reset state and quiet idle line
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst tx", 32'(tx_o), 32'd1);
    check("rst ready", 32'(s_ready_o), 32'd1);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst level", 32'(fifo_level_o), 32'd0);
    rst_ni = 1'b1;
    lows = 0;
    busyc = 0;
    repeat (1000) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) lows++;
      if (busy_o !== 1'b0) busyc++;
    end
    check("idle tx low cycles", 32'(lows), 32'd0);
    check("idle busy cycles", 32'(busyc), 32'd0);

    // 2: 0xA5, no parity, one stop
    push1(8'hA5);
    check("t2 level", 32'(fifo_level_o), 32'd1);
    check("t2 tx before pop", 32'(tx_o), 32'd1);
    check("t2 busy", 32'(busy_o), 32'd1);
    frame("t2", 8'hA5, 1'b0, 1'b0, 1'b0, 4, 0, -1, 1'b0, 1'b0);
    idle_chk("t2 end");

    // 3: parity even / odd, then two stop bits
    parity_en_i = 1'b1;
    parity_odd_i = 1'b0;
    push1(8'h03);
    frame("t3 even", 8'h03, 1'b1, 1'b0, 1'b0, 4, 0, -1, 1'b1, 1'b0);
    idle_chk("t3 even end");
    parity_odd_i = 1'b1;
    push1(8'h03);
    frame("t3 odd", 8'h03, 1'b1, 1'b1, 1'b0, 4, 0, -1, 1'b1, 1'b0);
    idle_chk("t3 odd end");
    parity_odd_i = 1'b0;
    stop2_i = 1'b1;
    push1(8'h03);
    frame("t3 stop2", 8'h03, 1'b1, 1'b0, 1'b1, 4, 0, -1, 1'b1, 1'b0);
    idle_chk("t3 stop2 end");
    parity_en_i = 1'b0;
    stop2_i = 1'b0;

    // 4: fill the FIFO with 0x10..0x15; 0x15 must be refused
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      check($sformatf("t4 level%0d", k), 32'(fifo_level_o), 32'(exp_lvl[k]));
      check($sformatf("t4 ready%0d", k), 32'(s_ready_o), 32'(exp_rdy[k]));
      s_valid_i = 1'b1;
      s_data_i  = DW'(16 + k);
    end
    @(negedge clk_i);
    s_valid_i = 1'b0;
    check("t4 level full", 32'(fifo_level_o), 32'd4);
    check("t4 ready full", 32'(s_ready_o), 32'd0);
    check("t4 tx start", 32'(tx_o), 32'd0);
    frame("t4 f0", 8'h10, 1'b0, 1'b0, 1'b0, 0, 5, -1, 1'b0, 1'b0);
    for (int k = 1; k < 5; k++) begin
      frame($sformatf("t4 f%0d", k), DW'(16 + k), 1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b0, 1'b0);
    end
    idle_chk("t4 end");
    check("t4 level end", 32'(fifo_level_o), 32'd0);

    // 5: parity change mid-frame applies to next frame; break mid-frame waits
    @(negedge clk_i);
    s_valid_i = 1'b1;
    s_data_i  = 8'h5A;
    @(negedge clk_i);
    s_data_i  = 8'h3D;
    @(negedge clk_i);
    s_valid_i = 1'b0;
    check("t5 start", 32'(tx_o), 32'd0);
    frame("t5 f1", 8'h5A, 1'b0, 1'b0, 1'b0, 0, 1, 3, 1'b1, 1'b0);
    frame("t5 f2", 8'h3D, 1'b1, 1'b0, 1'b0, 0, 0, 4, 1'b1, 1'b1);
    lows = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (tx_o === 1'b0) lows++;
    end
    check("t5 break low cycles", 32'(lows), 32'd20);
    check("t5 break busy", 32'(busy_o), 32'd1);
    break_i = 1'b0;
    parity_en_i = 1'b0;
    idle_chk("t5 after break");

    // 6: asynchronous reset during the third data bit with 2 words queued
    @(negedge clk_i);
    s_valid_i = 1'b1;
    s_data_i  = 8'h00;
    @(negedge clk_i);
    s_data_i  = 8'h81;
    @(negedge clk_i);
    s_data_i  = 8'h42;
    @(negedge clk_i);
    s_valid_i = 1'b0;
    check("t6 level queued", 32'(fifo_level_o), 32'd2);
    repeat (54) @(negedge clk_i);
    check("t6 tx data bit2", 32'(tx_o), 32'd0);
    #2 rst_ni = 1'b0;
    #1;
    check("t6 async tx", 32'(tx_o), 32'd1);
    check("t6 async level", 32'(fifo_level_o), 32'd0);
    check("t6 async busy", 32'(busy_o), 32'd0);
    check("t6 async ready", 32'(s_ready_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    lows = 0;
    busyc = 0;
    repeat (400) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) lows++;
      if (busy_o !== 1'b0) busyc++;
    end
    check("t6 no frame after reset", 32'(lows), 32'd0);
    check("t6 busy after reset", 32'(busyc), 32'd0);

    // 7: baud tick every third cycle; bits 1..7 of 0x01 give one low run
    // of 7 bits * 16 ticks * 3 cycles
    for (int k = 0; k < 700; k++) begin
      @(negedge clk_i);
      hist[k] = tx_o;
      baud_tick_i = (k % 3 == 0);
      if (k == 0) begin
        s_valid_i = 1'b1;
        s_data_i  = 8'h01;
      end else begin
        s_valid_i = 1'b0;
      end
    end
    baud_tick_i = 1'b1;
    run = 0;
    nruns = 0;
    second = -1;
    for (int k = 1; k < 700; k++) begin
      if (hist[k] === 1'b0) begin
        run++;
      end else if (run > 0) begin
        nruns++;
        if (nruns == 2) second = run;
        run = 0;
      end
    end
    check("t7 low runs", 32'(nruns), 32'd2);
    check("t7 low run cycles", 32'(second), 32'd336);
    idle_chk("t7 end");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
